// File: rtl/spi_bridge_pkg.sv
// Shared constants for the SPI command/data to register-bank bridge:
// FSM encoding, command-word fields and status-word layout.
package spi_bridge_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_W_DEF     = 7;

    localparam int unsigned STATE_W = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_DATA = 2'd1;
    localparam logic [1:0] ST_RD_TURN = 2'd2;
    localparam logic [1:0] ST_RD_DATA = 2'd3;

    localparam int unsigned ST_OVR_BIT   = 0;
    localparam int unsigned ST_SHORT_BIT = 1;
    localparam int unsigned ST_ID_LSB    = 8;
    localparam int unsigned ST_ID_W      = 8;
    localparam logic [ST_ID_W-1:0] STATUS_ID_DEF = 8'hA5;

    // Read-not-write flag sits in the command word MSB.
    function automatic int unsigned rnw_bit(input int unsigned data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Bundle of SPI-slave word stream and register-bank bus seen by the bridge.
interface spi_reg_bridge_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_W     = 7
);
    logic                  ss;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  rx_done;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [ADDR_W-1:0]     reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic                  reg_we;
    logic                  reg_re;
    logic [DATA_WIDTH-1:0] reg_rdata;

    modport master (
        input  ss, rx_word, rx_done, reg_rdata,
        output tx_word, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        output ss, rx_word, rx_done, reg_rdata,
        input  tx_word, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_reg_bridge.sv
// Decodes SPI command/data frames into register-bank read/write strobes.
// Define SPI_BRIDGE_AUTOINC_EN for burst transfers with auto-incrementing address.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned         ADDR_W     = ADDR_W_DEF,
    parameter logic [ST_ID_W-1:0]  STATUS_ID  = STATUS_ID_DEF
) (
    input  logic               clk,
    input  logic               rst,
    spi_reg_bridge_if.master   bus
);
    localparam int unsigned RNW = rnw_bit(DATA_WIDTH);

    function automatic logic [DATA_WIDTH-1:0] status_word(input logic e_short, input logic e_ovr);
        status_word = '0;
        status_word[ST_ID_LSB +: ST_ID_W] = STATUS_ID;
        status_word[ST_SHORT_BIT]         = e_short;
        status_word[ST_OVR_BIT]           = e_ovr;
    endfunction

    logic                  ss_s, ss_q, rx_ok;
    logic [STATE_W-1:0]    state, state_nxt;
    logic [ADDR_W-1:0]     addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt, tx_nxt;
    logic                  we_nxt, re_nxt, re_d, load_rd;
    logic                  got_word, got_nxt;
    logic                  err_short, err_ovr, short_nxt, ovr_nxt;

    sync_2ff #(.RST_VAL(1'b1)) u_ss_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.ss),
        .q   (ss_s)
    );

    // Words only count if the slave was selected in the cycle before they completed.
    assign rx_ok = bus.rx_done & ~ss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ss_q          <= 1'b1;
            re_d          <= 1'b0;
            got_word      <= 1'b0;
            err_short     <= 1'b0;
            err_ovr       <= 1'b0;
            bus.tx_word   <= status_word(1'b0, 1'b0);
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_we    <= 1'b0;
            bus.reg_re    <= 1'b0;
        end else begin
            state         <= state_nxt;
            ss_q          <= ss_s;
            re_d          <= bus.reg_re;
            got_word      <= got_nxt;
            err_short     <= short_nxt;
            err_ovr       <= ovr_nxt;
            bus.tx_word   <= tx_nxt;
            bus.reg_addr  <= addr_nxt;
            bus.reg_wdata <= wdata_nxt;
            bus.reg_we    <= we_nxt;
            bus.reg_re    <= re_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = bus.reg_addr;
        wdata_nxt = bus.reg_wdata;
        we_nxt    = 1'b0;
        re_nxt    = 1'b0;
        got_nxt   = got_word;
        short_nxt = err_short;
        ovr_nxt   = err_ovr;
        load_rd   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_ok && !ss_s) begin
                    addr_nxt  = ADDR_W'(bus.rx_word);
                    got_nxt   = 1'b0;
                    short_nxt = 1'b0;
                    ovr_nxt   = 1'b0;
                    state_nxt = bus.rx_word[RNW] ? ST_RD_TURN : ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (rx_ok) begin
                    if (!got_word) begin
                        we_nxt    = 1'b1;
                        wdata_nxt = bus.rx_word;
                        got_nxt   = 1'b1;
                    end else begin
`ifdef SPI_BRIDGE_AUTOINC_EN
                        we_nxt    = 1'b1;
                        wdata_nxt = bus.rx_word;
                        addr_nxt  = bus.reg_addr + ADDR_W'(1);
`else
                        ovr_nxt   = 1'b1;
`endif
                    end
                end
            end
            ST_RD_TURN: begin
                // Dummy word done -> read strobe; read data lands two cycles later.
                if (re_d) begin
                    load_rd   = 1'b1;
                    got_nxt   = 1'b0;
                    state_nxt = ST_RD_DATA;
                end else if (rx_ok && !got_word) begin
                    re_nxt  = 1'b1;
                    got_nxt = 1'b1;
                end
            end
            ST_RD_DATA: begin
                load_rd = re_d;
                if (rx_ok) begin
`ifdef SPI_BRIDGE_AUTOINC_EN
                    addr_nxt = bus.reg_addr + ADDR_W'(1);
                    re_nxt   = 1'b1;
`else
                    if (got_word) ovr_nxt = 1'b1;
                    else          got_nxt = 1'b1;
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Deselect ends the frame after any coincident word has been handled.
        if (ss_s) begin
            if ((state == ST_WR_DATA || state == ST_RD_TURN) && !got_nxt) short_nxt = 1'b1;
            state_nxt = ST_IDLE;
        end

        if (ss_s)                     tx_nxt = status_word(short_nxt, ovr_nxt);
        else if (load_rd)             tx_nxt = bus.reg_rdata;
        else if (state == ST_RD_DATA) tx_nxt = bus.tx_word;
        else                          tx_nxt = status_word(short_nxt, ovr_nxt);
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: frame vector table plus register-strobe scoreboard.
module tb_spi_reg_bridge;
    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 7;
    localparam int unsigned GAP = 8;
`ifdef SPI_BRIDGE_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct packed {
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } strb_t;

    typedef struct {
        int                 n;
        logic [3:0][DW-1:0] mosi;
        logic [3:0][DW-1:0] miso;
        int                 ns;
        strb_t [2:0]        strb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_reg_bridge_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    spi_reg_bridge #(.DATA_WIDTH(DW), .ADDR_W(AW), .STATUS_ID(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks = 0;
    int    passed = 0;
    strb_t sb[$];
    vec_t  vq[$];
    logic [DW-1:0] mem [128];

    // Register bank model: read data valid the cycle after reg_re.
    always @(posedge clk) begin
        if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
        if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (bus.reg_we || bus.reg_re)) begin
            strb_t a, e;
            a = '{re: bus.reg_re, addr: bus.reg_addr, data: (bus.reg_we ? bus.reg_wdata : '0)};
            chk("we_re_exclusive", 32'({bus.reg_we, bus.reg_re} == 2'b11), 32'(0));
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe: got %h expected none", a);
            end else begin
                e = sb.pop_front();
                chk("strobe", 32'(a), 32'(e));
            end
        end
    end

    function automatic logic [3:0][DW-1:0] w4(input logic [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction
    function automatic strb_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return '{re: 1'b0, addr: a, data: d};
    endfunction
    function automatic strb_t rd(input logic [AW-1:0] a);
        return '{re: 1'b1, addr: a, data: '0};
    endfunction
    function automatic strb_t [2:0] s3(input strb_t a, b, c);
        return {c, b, a};
    endfunction

    function automatic void addv(input int n, input logic [3:0][DW-1:0] mo, mi,
                                 input int ns, input strb_t [2:0] st);
        vec_t v;
        v.n = n; v.mosi = mo; v.miso = mi; v.ns = ns; v.strb = st;
        vq.push_back(v);
    endfunction

    // Read frame: cmd, dummy, data word; autoinc also prefetches addr+1.
    function automatic void addrd(input logic [AW-1:0] a, input logic [DW-1:0] st0,
                                  input logic [DW-1:0] d);
        addv(3, w4({1'b1, 8'h00, a}, 16'h0, 16'h0, 16'h0), w4(st0, 16'hA500, d, 16'h0),
             AUTO ? 2 : 1, s3(rd(a), rd(a + 7'd1), '0));
    endfunction

    task automatic frame(input string name, input int n, input logic [3:0][DW-1:0] mosi,
                         input logic [3:0][DW-1:0] miso);
        bus.ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            repeat (GAP) @(negedge clk);
            chk($sformatf("%s_miso%0d", name, k), 32'(bus.tx_word), 32'(miso[k]));
            bus.rx_word = mosi[k];
            bus.rx_done = 1'b1;
            @(negedge clk);
            bus.rx_done = 1'b0;
        end
        repeat (GAP) @(negedge clk);
        bus.ss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_word(input logic [DW-1:0] w);
        bus.rx_word = w;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h0C00 | DW'(i);
        mem[3] = 16'hBEEF;
        bus.reg_rdata = '0;
        bus.ss = 1'b1; bus.rx_done = 1'b0; bus.rx_word = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_tx_word", 32'(bus.tx_word), 32'h0000_A500);
        chk("rst_reg_addr", 32'(bus.reg_addr), 32'(0));
        chk("rst_reg_wdata", 32'(bus.reg_wdata), 32'(0));
        chk("rst_strobes", 32'({bus.reg_we, bus.reg_re}), 32'(0));

        addv(2, w4(16'h0005, 16'h1234, 0, 0), w4(16'hA500, 16'hA500, 0, 0), 1,
             s3(wr(7'h05, 16'h1234), '0, '0));
        addrd(7'h03, 16'hA500, 16'hBEEF);
        addrd(7'h05, 16'hA500, 16'h1234);
        addv(1, w4(16'h0002, 0, 0, 0), w4(16'hA500, 0, 0, 0), 0, '0);
        addv(2, w4(16'h0010, 16'h5555, 0, 0), w4(16'hA502, 16'hA500, 0, 0), 1,
             s3(wr(7'h10, 16'h5555), '0, '0));
        if (AUTO)
            addv(4, w4(16'h007F, 16'h1111, 16'h2222, 16'h3333),
                 w4(16'hA500, 16'hA500, 16'hA500, 16'hA500), 3,
                 s3(wr(7'h7F, 16'h1111), wr(7'h00, 16'h2222), wr(7'h01, 16'h3333)));
        else
            addv(4, w4(16'h007F, 16'h1111, 16'h2222, 16'h3333),
                 w4(16'hA500, 16'hA500, 16'hA500, 16'hA501), 1,
                 s3(wr(7'h7F, 16'h1111), '0, '0));
        addrd(7'h10, AUTO ? 16'hA500 : 16'hA501, 16'h5555);
        addrd(7'h00, 16'hA500, AUTO ? 16'h2222 : 16'h0C00);
        addrd(7'h7F, 16'hA500, 16'h1111);

        foreach (vq[i]) begin
            for (int j = 0; j < vq[i].ns; j++) sb.push_back(vq[i].strb[j]);
            frame($sformatf("v%0d", i), vq[i].n, vq[i].mosi, vq[i].miso);
            chk($sformatf("v%0d_sb_empty", i), 32'(sb.size()), 32'(0));
        end

        // Words completing while deselected must be ignored.
        for (int k = 0; k < 3; k++) begin
            repeat (GAP) @(negedge clk);
            pulse_word(16'h0006);
        end
        repeat (GAP) @(negedge clk);
        chk("ssh_tx_word", 32'(bus.tx_word), 32'h0000_A500);

        // Reset mid write frame after the command word.
        bus.ss = 1'b0;
        repeat (4 + GAP) @(negedge clk);
        pulse_word(16'h0020);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.ss = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstmid_tx_word", 32'(bus.tx_word), 32'h0000_A500);
        sb.push_back(rd(7'h03));
        if (AUTO) sb.push_back(rd(7'h04));
        frame("rstmid_rd", 3, w4(16'h8003, 0, 0, 0), w4(16'hA500, 16'hA500, 16'hBEEF, 0));

        // Data word completes in the very cycle the synchronized select rises.
        bus.ss = 1'b0;
        repeat (4 + GAP) @(negedge clk);
        pulse_word(16'h0006);
        repeat (GAP) @(negedge clk);
        sb.push_back(wr(7'h06, 16'hABCD));
        bus.ss = 1'b1;
        repeat (2) @(negedge clk);
        pulse_word(16'hABCD);
        repeat (6) @(negedge clk);
        chk("coinc_sb_empty", 32'(sb.size()), 32'(0));
        chk("coinc_tx_word", 32'(bus.tx_word), 32'h0000_A500);
        sb.push_back(rd(7'h06));
        if (AUTO) sb.push_back(rd(7'h07));
        frame("coinc_rd", 3, w4(16'h8006, 0, 0, 0), w4(16'hA500, 16'hA500, 16'hABCD, 0));

        chk("final_sb_empty", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
